// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants and instruction decode for the bus control sequencer
package bus_pkg;

   localparam int SRC_R0     = 0;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHI    = 18;
   localparam int SRC_ZLO    = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_C      = 23;
   localparam int SRC_W      = 24;

   localparam logic [4:0] OP_MOV  = 5'b10000;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_T0   = 3'd1;
   localparam logic [2:0] ST_T1   = 3'd2;
   localparam logic [2:0] ST_T2   = 3'd3;
   localparam logic [2:0] ST_T3   = 3'd4;
   localparam logic [2:0] ST_HALT = 3'd5;

   typedef struct packed {
      logic [4:0] op;
      logic [3:0] ra;
      logic [3:0] rb;
   } instr_t;

   function automatic instr_t decode(input logic [12:0] ir_hi);
      instr_t d;
      d.op = ir_hi[12:8];
      d.ra = ir_hi[7:4];
      d.rb = ir_hi[3:0];
      return d;
   endfunction

endpackage

// File: rtl/dec4to16.sv
// rtl/dec4to16.sv - 4-bit to one-hot-16 decoder with enable
module dec4to16 (
   input  logic [3:0]  sel_i,
   input  logic        en_i,
   output logic [15:0] onehot_o
);

   assign onehot_o = en_i ? (16'h0001 << sel_i) : 16'h0000;

endmodule

// File: rtl/bus_ctrl_sequencer.sv
// rtl/bus_ctrl_sequencer.sv - T0..T3 fetch/execute sequencer driving bus source strobes and load enables
module bus_ctrl_sequencer
   import bus_pkg::*;
#(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             run,
   input  logic [31:0]      ir,
   input  logic             mem_ready,
   output logic [23:0]      out_sel,
   output logic [15:0]      r_in,
   output logic             pc_in,
   output logic             mar_in,
   output logic             mdr_in,
   output logic             ir_in,
   output logic             z_in,
   output logic             inc_pc,
   output logic             mem_read,
   output logic             halted,
   output logic             illegal,
   output logic             mem_err,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

   logic [2:0]       state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic             first_q, first_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   instr_t      ins;
   logic        in_t0, in_t1, in_t2, in_t3;
   logic        is_mov, op_legal;
   logic [15:0] src_onehot;
   logic        unused_ir_bits;

   assign ins            = decode(ir[31:19]);
   assign unused_ir_bits = ^ir[18:0];

   assign in_t0    = (state_q == ST_T0);
   assign in_t1    = (state_q == ST_T1);
   assign in_t2    = (state_q == ST_T2);
   assign in_t3    = (state_q == ST_T3);
   assign op_legal = (ins.op == OP_MOV) || (ins.op == OP_NOP) || (ins.op == OP_HALT);
   assign is_mov   = in_t3 && (ins.op == OP_MOV);

   dec4to16 u_src_dec (.sel_i(ins.rb), .en_i(is_mov), .onehot_o(src_onehot));
   dec4to16 u_dst_dec (.sel_i(ins.ra), .en_i(is_mov), .onehot_o(r_in));

   // T1 is only ever entered from T0, so "first T1 cycle" is simply "previous state was T0"
   assign first_d = in_t0;
   assign wait_d  = in_t1 ? (wait_q + 8'd1) : 8'd0;

   always_comb begin
      state_d   = state_q;
      mem_err_d = mem_err_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: if (run) state_d = ST_T0;
         ST_T0:   state_d = ST_T1;
         ST_T1: begin
            if (mem_ready) begin
               state_d = ST_T2;
            end else if (wait_d == WAIT_LIMIT) begin
               state_d   = ST_HALT;
               mem_err_d = 1'b1;
            end
         end
         ST_T2:   state_d = ST_T3;
         ST_T3: begin
            if (ins.op == OP_HALT) begin
               state_d = ST_HALT;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = run ? ST_T0 : ST_IDLE;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q   <= ST_IDLE;
         wait_q    <= 8'd0;
         first_q   <= 1'b0;
         mem_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         first_q   <= first_d;
         mem_err_q <= mem_err_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      out_sel          = '0;
      out_sel[15:0]    = src_onehot;
      out_sel[SRC_ZLO] = in_t1 && first_q;
      out_sel[SRC_PC]  = in_t0;
      out_sel[SRC_MDR] = in_t2;
   end

   assign pc_in     = in_t1 && first_q;
   assign mar_in    = in_t0;
   assign inc_pc    = in_t0;
   assign z_in      = in_t0;
   assign mem_read  = in_t1;
   assign mdr_in    = in_t1 && mem_ready;
   assign ir_in     = in_t2;
   assign halted    = (state_q == ST_HALT);
   assign illegal   = in_t3 && !op_legal;
   assign mem_err   = mem_err_q;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_bus_ctrl_sequencer.sv
// tb/tb_bus_ctrl_sequencer.sv - directed and randomized instruction-level checks of bus_ctrl_sequencer
module tb_bus_ctrl_sequencer;

   localparam int WAIT_MAX = 5;
   localparam int CNT_W    = 4;

   localparam logic [6:0] F_PC  = 7'b1000000;
   localparam logic [6:0] F_MAR = 7'b0100000;
   localparam logic [6:0] F_MDR = 7'b0010000;
   localparam logic [6:0] F_IR  = 7'b0001000;
   localparam logic [6:0] F_Z   = 7'b0000100;
   localparam logic [6:0] F_INC = 7'b0000010;
   localparam logic [6:0] F_RD  = 7'b0000001;

   logic             clk = 1'b0;
   logic             clr = 1'b0;
   logic             run = 1'b0;
   logic [31:0]      ir  = 32'h0;
   logic             mem_ready = 1'b0;
   logic [23:0]      out_sel;
   logic [15:0]      r_in;
   logic             pc_in, mar_in, mdr_in, ir_in, z_in, inc_pc, mem_read;
   logic             halted, illegal, mem_err;
   logic [CNT_W-1:0] instr_cnt;
   logic [53:0]      obs;

   int n_chk  = 0;
   int n_pass = 0;
   int cycles = 0;
   int cnt_m  = 0;
   bit merr_m = 0;
   bit halt_m = 0;

   bus_ctrl_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
      .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
      .out_sel(out_sel), .r_in(r_in), .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in),
      .ir_in(ir_in), .z_in(z_in), .inc_pc(inc_pc), .mem_read(mem_read),
      .halted(halted), .illegal(illegal), .mem_err(mem_err), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   assign obs = {halted, illegal, mem_err, instr_cnt, out_sel, r_in,
                 pc_in, mar_in, mdr_in, ir_in, z_in, inc_pc, mem_read};

   function automatic logic [53:0] expect_v(int src, int dst, logic [6:0] f, bit ill);
      logic [23:0] s;
      logic [15:0] d;
      s = '0;
      d = '0;
      if (src >= 0) s[src] = 1'b1;
      if (dst >= 0) d[dst] = 1'b1;
      return {halt_m, ill, merr_m, 4'(cnt_m), s, d, f};
   endfunction

   task automatic check(string tag, logic [53:0] got, logic [53:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   task automatic check_onehot0(string tag);
      n_chk++;
      assert ($onehot0(out_sel) && $onehot0(r_in)) n_pass++;
      else $error("FAIL %s: observed out_sel=%h r_in=%h expected onehot0", tag, out_sel, r_in);
   endtask

   task automatic cyc_in(bit c, bit r, logic [31:0] irv, bit mr);
      @(posedge clk);
      #1;
      clr = c; run = r; ir = irv; mem_ready = mr;
      #1;
      cycles++;
   endtask

   task automatic do_reset();
      cyc_in(1'b0, 1'b1, $urandom, 1'($urandom));
      cnt_m = 0; merr_m = 0; halt_m = 0;
      repeat (2) begin
         cyc_in(1'b0, 1'b1, $urandom, 1'($urandom));
         check("reset", obs, expect_v(-1, -1, 7'b0, 1'b0));
      end
      cyc_in(1'b1, 1'b1, $urandom, 1'($urandom));
      check("idle_after_reset", obs, expect_v(-1, -1, 7'b0, 1'b0));
   endtask

   // One instruction from T0 onward; lat = T1 cycle on which memory answers, 0 = never
   task automatic do_instr(logic [31:0] irv, int lat, bit run_after);
      int limit;
      int src, dst;
      bit mr, ill;
      logic [4:0] op;
      cyc_in(1'b1, 1'($urandom), $urandom, 1'($urandom));
      check("t0", obs, expect_v(20, -1, F_MAR | F_INC | F_Z, 1'b0));
      limit = (lat == 0) ? WAIT_MAX : lat;
      for (int k = 1; k <= limit; k++) begin
         mr = (k == lat);
         cyc_in(1'b1, 1'($urandom), $urandom, mr);
         check("t1", obs, expect_v((k == 1) ? 19 : -1, -1,
               ((k == 1) ? F_PC : 7'b0) | F_RD | (mr ? F_MDR : 7'b0), 1'b0));
      end
      if (lat == 0) begin
         merr_m = 1; halt_m = 1;
         repeat (3) begin
            cyc_in(1'b1, 1'b1, $urandom, 1'($urandom));
            check("timeout_halt", obs, expect_v(-1, -1, 7'b0, 1'b0));
         end
         return;
      end
      cyc_in(1'b1, 1'($urandom), $urandom, 1'($urandom));
      check("t2", obs, expect_v(21, -1, F_IR, 1'b0));
      op  = irv[31:27];
      src = -1; dst = -1; ill = 0;
      if (op == 5'b10000) begin
         src = int'(irv[22:19]);
         dst = int'(irv[26:23]);
      end else if (op != 5'b11010 && op != 5'b11011) begin
         ill = 1;
      end
      cyc_in(1'b1, run_after, irv, 1'($urandom));
      check("t3", obs, expect_v(src, dst, 7'b0, ill));
      check_onehot0("t3_onehot");
      if (op == 5'b11011) begin
         halt_m = 1;
         repeat (3) begin
            cyc_in(1'b1, 1'b1, $urandom, 1'($urandom));
            check("halt_op", obs, expect_v(-1, -1, 7'b0, 1'b0));
         end
         return;
      end
      cnt_m = (cnt_m + 1) % (1 << CNT_W);
      if (!run_after) begin
         repeat ($urandom_range(1, 3)) begin
            cyc_in(1'b1, 1'b0, $urandom, 1'($urandom));
            check("idle", obs, expect_v(-1, -1, 7'b0, 1'b0));
         end
         cyc_in(1'b1, 1'b1, $urandom, 1'($urandom));
         check("idle_run", obs, expect_v(-1, -1, 7'b0, 1'b0));
      end
   endtask

   function automatic logic [31:0] rand_instr(int kind);
      logic [31:0] v;
      logic [4:0]  op;
      v = $urandom;
      case (kind)
         0: op = 5'b11011;
         1: begin
            op = 5'($urandom);
            if (op == 5'b10000 || op == 5'b11010 || op == 5'b11011) op = 5'b00001;
         end
         2: op = 5'b11010;
         default: op = 5'b10000;
      endcase
      v[31:27] = op;
      return v;
   endfunction

   initial begin
      int kind, lat;
      do_reset();
      do_instr(32'h8098_0000, 3, 1'b1);
      do_instr(32'h0812_3456, 1, 1'b1);
      do_instr(32'hD000_0000, WAIT_MAX, 1'b0);

      // clear while in T1 with memory answering
      cyc_in(1'b1, 1'b1, $urandom, 1'b0);
      check("t0_pre_clr", obs, expect_v(20, -1, F_MAR | F_INC | F_Z, 1'b0));
      cyc_in(1'b0, 1'b1, $urandom, 1'b1);
      check("t1_clr_cycle", obs, expect_v(19, -1, F_PC | F_RD | F_MDR, 1'b0));
      cnt_m = 0; merr_m = 0; halt_m = 0;
      cyc_in(1'b0, 1'b1, $urandom, 1'b1);
      check("clr_mid_t1", obs, expect_v(-1, -1, 7'b0, 1'b0));
      cyc_in(1'b1, 1'b1, $urandom, 1'b1);
      check("idle_after_clr", obs, expect_v(-1, -1, 7'b0, 1'b0));

      do_instr(32'h8098_0000, 0, 1'b1);
      do_reset();
      do_instr(32'hD800_0000, 2, 1'b1);
      do_reset();

      while (cycles < 9500) begin
         kind = int'($urandom_range(0, 19));
         lat  = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, WAIT_MAX));
         do_instr(rand_instr((kind == 0) ? 0 : (kind < 4) ? 1 : (kind < 7) ? 2 : 3),
                  lat, ($urandom_range(0, 3) != 0));
         if (halt_m) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
